// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single physical-memory port between the I-cache
// and the D-cache. One 128-bit line transaction is latched at a time, driven
// onto pmem, and completed with a one-cycle response pulse to its owner.
// Simultaneous requests are resolved round-robin.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   I_address, I_read                I-cache miss request
//   I_rdata, I_resp                  I-cache line return and response pulse
//   D_address, D_read, D_write       D-cache fill / write-back request
//   D_wdata                          D-cache write-back line
//   D_rdata, D_resp                  D-cache line return and response pulse
//   pmem_address, pmem_read,
//   pmem_write, pmem_wdata           physical-memory command (line aligned)
//   pmem_rdata, pmem_resp            physical-memory read line and completion
module cache_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  I_address,
  input  logic         I_read,
  output logic [127:0] I_rdata,
  output logic         I_resp,
  input  logic [15:0]  D_address,
  input  logic         D_read,
  input  logic         D_write,
  input  logic [127:0] D_wdata,
  output logic [127:0] D_rdata,
  output logic         D_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy, StResp} state_e;

  state_e       state_q, state_d;
  logic         last_grant_q, last_grant_d;  // 1 = D was granted on the last tie
  logic         owner_q, owner_d;            // 1 = D owns the transaction
  logic         op_write_q, op_write_d;
  logic [15:0]  addr_q, addr_d;
  logic [127:0] wbuf_q, wbuf_d;
  logic [127:0] line_q, line_d;

  logic i_req, d_req, grant_d, busy;

  assign i_req = I_read;
  assign d_req = D_read | D_write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wbuf_d       = wbuf_q;
    line_d       = line_q;
    grant_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          // On a tie D wins unless D took the previous tie.
          grant_d = d_req & (~i_req | ~last_grant_q);
          // Only ties advance the round-robin pointer.
          if (i_req && d_req) last_grant_d = grant_d;
          owner_d    = grant_d;
          addr_d     = grant_d ? {D_address[15:4], 4'b0000} : {I_address[15:4], 4'b0000};
          op_write_d = grant_d & D_write;
          wbuf_d     = D_wdata;
          state_d    = grant_d ? StDBusy : StIBusy;
        end
      end
      StIBusy, StDBusy: begin
        if (pmem_resp) begin
          if (!op_write_q) line_d = pmem_rdata;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b0;
      owner_q      <= 1'b0;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wbuf_q       <= '0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wbuf_q       <= wbuf_d;
      line_q       <= line_d;
    end
  end

  // Outputs depend only on state and latched registers, so reset drops the
  // strobes immediately and pmem_resp never reaches *_resp combinationally.
  always_comb begin
    busy         = (state_q == StIBusy) || (state_q == StDBusy);
    pmem_read    = busy & ~op_write_q;
    pmem_write   = busy & op_write_q;
    pmem_address = addr_q;
    pmem_wdata   = wbuf_q;
    I_resp       = (state_q == StResp) & ~owner_q;
    D_resp       = (state_q == StResp) & owner_q;
    I_rdata      = line_q;
    D_rdata      = line_q;
  end

endmodule
